// File: rtl/rmst_pkg.sv
// rmst_pkg: shared definitions for the read-master tile scheduler.
//   - TILE_LEN_DEFAULT : default maximum words per issued tile
//   - rmst_state_e     : scheduler FSM state encoding
//   - min_u            : unsigned minimum used to clip a tile to the remaining length
package rmst_pkg;

    localparam int unsigned TILE_LEN_DEFAULT = 128;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWait   = 2'd2,
        StUpdate = 2'd3
    } rmst_state_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rmst_sched_if.sv
// rmst_sched_if: scheduler <-> read-master engine tile bus.
//   trans_start : one-cycle tile start (scheduler -> engine)
//   trans_raddr : tile byte address      (scheduler -> engine)
//   trans_iolen : tile word count        (scheduler -> engine)
//   trans_sel   : requester owning tile  (scheduler -> engine)
//   trans_done  : tile finished          (engine -> scheduler)
// Modports: master = scheduler side, slave = engine side.
interface rmst_sched_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) ();

    logic          trans_start;
    logic [DW-1:0] trans_raddr;
    logic [AW-1:0] trans_iolen;
    logic          trans_sel;
    logic          trans_done;

    modport master (
        output trans_start,
        output trans_raddr,
        output trans_iolen,
        output trans_sel,
        input  trans_done
    );

    modport slave (
        input  trans_start,
        input  trans_raddr,
        input  trans_iolen,
        input  trans_sel,
        output trans_done
    );

endinterface

// File: rtl/rmst_job_tracker.sv
// rmst_job_tracker: per-requester job state (active flag, current address,
// remaining words), start acceptance and post-tile update.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle job request, addr/len sampled with it
//   addr, len : job base byte address and length in words
//   upd       : one-cycle update strobe after a tile of this job finished
//   upd_len   : word count of the finished tile
//   active    : job in progress
//   cur_addr  : byte address of the next tile
//   rem       : words still to be issued
//   done      : one-cycle job-complete pulse
module rmst_job_tracker #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] addr,
    input  logic [AW-1:0] len,
    input  logic          upd,
    input  logic [AW-1:0] upd_len,
    output logic          active,
    output logic [DW-1:0] cur_addr,
    output logic [AW-1:0] rem,
    output logic          done
);

    logic          active_q;
    logic [DW-1:0] addr_q;
    logic [AW-1:0] rem_q;
    logic          done_q;

    logic accept;
    logic zero_job;
    logic last_tile;

    // A start is only honoured while idle; this also drops a start landing on
    // the final-tile update edge, since active is still set on that edge.
    assign accept    = start && !active_q;
    assign zero_job  = accept && (len == '0);
    assign last_tile = upd && (rem_q == upd_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= zero_job || last_tile;
            if (upd) begin
                addr_q <= addr_q + (DW'(upd_len) << 2);
                rem_q  <= rem_q - upd_len;
                if (last_tile) begin
                    active_q <= 1'b0;
                end
            end else if (accept && !zero_job) begin
                addr_q   <= addr;
                rem_q    <= len;
                active_q <= 1'b1;
            end
        end
    end

    assign active   = active_q;
    assign cur_addr = addr_q;
    assign rem      = rem_q;
    assign done     = done_q;

    upd_only_when_active: assert property (@(posedge clk) disable iff (rst) upd |-> active_q);
    upd_within_rem: assert property (@(posedge clk) disable iff (rst) upd |-> (upd_len <= rem_q));

endmodule

// File: rtl/rmst_sched.sv
// rmst_sched: two-requester round-robin tile scheduler for a read-master engine.
// Each requester submits a job (base byte address, length in words); the job is
// cut into tiles of at most TILE_LEN words which are issued one at a time to
// the engine, alternating between requesters when both can accept data.
//   clk, rst                    : clock, asynchronous active-high reset
//   reqN_start/addr/len         : one-cycle job request with its parameters
//   reqN_fifo_almost_full       : requester cannot take another tile right now
//   reqN_done                   : one-cycle job-complete pulse
//   eng (rmst_sched_if.master)  : tile bus to the engine (start/raddr/iolen/sel/done)
module rmst_sched
    import rmst_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 32,
    parameter int unsigned TILE_LEN = TILE_LEN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_start,
    input  logic [DW-1:0] req0_addr,
    input  logic [AW-1:0] req0_len,
    input  logic          req0_fifo_almost_full,
    output logic          req0_done,
    input  logic          req1_start,
    input  logic [DW-1:0] req1_addr,
    input  logic [AW-1:0] req1_len,
    input  logic          req1_fifo_almost_full,
    output logic          req1_done,
    rmst_sched_if.master  eng
);

    rmst_state_e   state_q;
    logic          last_grant_q;
    logic          start_q;
    logic [DW-1:0] raddr_q;
    logic [AW-1:0] iolen_q;
    logic          sel_q;

    logic          active0, active1;
    logic [DW-1:0] cur_addr0, cur_addr1;
    logic [AW-1:0] rem0, rem1;
    logic          upd0, upd1;

    logic          elig0, elig1;
    logic          grant;
    logic [DW-1:0] grant_addr;
    logic [AW-1:0] grant_rem;
    logic [AW-1:0] tile_words;

    rmst_job_tracker #(
        .AW (AW),
        .DW (DW)
    ) u_trk0 (
        .clk      (clk),
        .rst      (rst),
        .start    (req0_start),
        .addr     (req0_addr),
        .len      (req0_len),
        .upd      (upd0),
        .upd_len  (iolen_q),
        .active   (active0),
        .cur_addr (cur_addr0),
        .rem      (rem0),
        .done     (req0_done)
    );

    rmst_job_tracker #(
        .AW (AW),
        .DW (DW)
    ) u_trk1 (
        .clk      (clk),
        .rst      (rst),
        .start    (req1_start),
        .addr     (req1_addr),
        .len      (req1_len),
        .upd      (upd1),
        .upd_len  (iolen_q),
        .active   (active1),
        .cur_addr (cur_addr1),
        .rem      (rem1),
        .done     (req1_done)
    );

    // almost_full only gates the grant decision; a tile already in flight runs on.
    assign elig0 = active0 && !req0_fifo_almost_full;
    assign elig1 = active1 && !req1_fifo_almost_full;

    always_comb begin
        grant = 1'b0;
        if (elig0 && elig1) begin
            grant = !last_grant_q;
        end else begin
            grant = elig1;
        end
    end

    assign grant_addr = grant ? cur_addr1 : cur_addr0;
    assign grant_rem  = grant ? rem1 : rem0;
    assign tile_words = AW'(min_u(32'(grant_rem), TILE_LEN));

    // The owning tracker advances in the single UPDATE cycle.
    assign upd0 = (state_q == StUpdate) && !sel_q;
    assign upd1 = (state_q == StUpdate) && sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            start_q      <= 1'b0;
            raddr_q      <= '0;
            iolen_q      <= '0;
            sel_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (elig0 || elig1) begin
                        sel_q   <= grant;
                        raddr_q <= grant_addr;
                        iolen_q <= tile_words;
                        start_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    start_q <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (eng.trans_done) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    last_grant_q <= sel_q;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign eng.trans_start = start_q;
    assign eng.trans_raddr = raddr_q;
    assign eng.trans_iolen = iolen_q;
    assign eng.trans_sel   = sel_q;

    start_one_cycle: assert property (@(posedge clk) disable iff (rst) start_q |=> !start_q);
    start_has_words: assert property (@(posedge clk) disable iff (rst)
        start_q |-> ((iolen_q != '0) && (32'(iolen_q) <= TILE_LEN)));

endmodule

// File: doc/rmst_sched.md
RMST_SCHED -- requirements
Module: rmst_sched

Interface
REQ-001 SHALL have parameter AW, default 12, meaning the word-length width.
REQ-002 SHALL have parameter DW, default 32, meaning the byte-address width.
REQ-003 SHALL have parameter TILE_LEN, default 128, meaning the maximum words per transfer.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports req0_start and req1_start, input, 1 bit each: single-cycle job request.
REQ-007 SHALL have ports req0_addr and req1_addr, input, DW bits each: job base byte address, sampled with start.
REQ-008 SHALL have ports req0_len and req1_len, input, AW bits each: job length in words, sampled with start.
REQ-009 SHALL have ports req0_fifo_almost_full and req1_fifo_almost_full, input, 1 bit each: requester load FIFO has no room for a tile.
REQ-010 SHALL have ports req0_done and req1_done, output, 1 bit each: single-cycle job-complete pulse.
REQ-011 SHALL have port trans_start, output, 1 bit: single-cycle start to the read-master engine.
REQ-012 SHALL have port trans_raddr, output, DW bits: tile byte address.
REQ-013 SHALL have port trans_iolen, output, AW bits: tile word count.
REQ-014 SHALL have port trans_sel, output, 1 bit: requester owning the current tile.
REQ-015 SHALL have port trans_done, input, 1 bit: engine finished the current tile.

Function
REQ-016 Per requester: active flag, cur_addr (DW bits), rem (AW bits).
REQ-017 Start sampled while not active SHALL load cur_addr and rem and set active; start while active SHALL be ignored, including on the final-tile UPDATE edge.
REQ-018 Start with len=0 SHALL NOT set active; reqN_done SHALL pulse on the next cycle and no tile SHALL be issued.
REQ-019 Requester is eligible when active=1 and fifo_almost_full=0.
REQ-020 FSM states: IDLE, ISSUE, WAIT, UPDATE; IDLE stays while no requester is eligible.
REQ-021 IDLE->ISSUE when any requester is eligible; if both are eligible, grant the one not equal to last_grant (round-robin per tile).
REQ-022 On IDLE->ISSUE the block SHALL latch trans_sel=grant, trans_raddr=cur_addr and trans_iolen=min(rem, TILE_LEN).
REQ-023 trans_start SHALL be 1 exactly during ISSUE; ISSUE->WAIT unconditionally.
REQ-024 WAIT->UPDATE on trans_done=1; trans_done in any other state SHALL be ignored.
REQ-025 UPDATE SHALL set cur_addr += trans_iolen<<2 (mod 2^DW) and rem -= trans_iolen for trans_sel, set last_grant=trans_sel, then go to IDLE.
REQ-026 If rem becomes 0 in UPDATE, active SHALL clear and reqN_done SHALL pulse for exactly the cycle after UPDATE.
REQ-027 Minimum latency: start sampled at edge n gives trans_start high in the cycle after edge n+1.
REQ-028 almost_full is checked only in IDLE; asserting it during WAIT SHALL NOT abort the tile.
REQ-029 trans_raddr, trans_iolen and trans_sel SHALL hold from ISSUE through UPDATE.

Reset
REQ-030 rst SHALL force: state IDLE, both active=0, cur_addr=0, rem=0, last_grant=1 (req0 wins the first tie), all outputs 0.
REQ-031 Reset mid-job SHALL abandon the job with no done pulse; the next start SHALL be accepted normally.

Structure
REQ-032 Package rmst_pkg SHALL hold the FSM state encoding and the TILE_LEN default.
REQ-033 Sub-module rmst_job_tracker (active/cur_addr/rem, start-accept, update) SHALL be instantiated once per requester.

Verification
REQ-034 Scenario: req0 addr 0x1000, len 300 -> tiles (0x1000,128), (0x1200,128), (0x1400,44); then one req0_done pulse.
REQ-035 Scenario: same-cycle starts, req0 (0x0,256) and req1 (0x8000,256) -> sel order 0,1,0,1; addresses 0x0, 0x8000, 0x200, 0x8200; req0_done before req1_done.
REQ-036 Scenario: req1_fifo_almost_full=1 throughout req1 (0x8000,256) and req0 (0x0,256) -> only sel=0 tiles issue; after deassert, req1 tiles issue.
REQ-037 Scenario: req0 len 0 -> req0_done pulse one cycle later; trans_start stays 0.
REQ-038 Scenario: rst during WAIT -> all outputs 0, no done pulse; new req1 (0x40,10) -> single tile (0x40,10).
REQ-039 Scenario: req0_start while req0 is active, and trans_done in IDLE -> both ignored; tile sequence unchanged.
